// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: multi-channel servo PWM from one shared frame counter.
// Positions are written any time and take effect only at frame boundaries, optionally slew-limited.
module servo_pwm_multi #(
    parameter int NUM_CH       = 4,
    parameter int POS_W        = 8,
    parameter int FRAME_CYCLES = 1000000,
    parameter int MIN_CYCLES   = 31000,
    parameter int STEP_CYCLES  = 392,
    parameter int SLEW_STEP    = 0,
    parameter int RESET_POS    = 128,
    localparam int CH_W        = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
    localparam int WIDTH_W     = $clog2(FRAME_CYCLES) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [POS_W-1:0]  wr_pos,
    output logic              wr_err,
    output logic              frame_start,
    output logic [NUM_CH-1:0] pulse
);
    logic [WIDTH_W-1:0] cnt;
    logic [NUM_CH-1:0] hit;
    logic last, boundary;

    // 64-bit intermediate keeps the product exact before saturating below 100% duty
    function automatic logic [WIDTH_W-1:0] calc_w(input logic [POS_W-1:0] p);
        logic [63:0] f;
        f = 64'(MIN_CYCLES) + 64'(p) * 64'(STEP_CYCLES);
        return f > 64'(FRAME_CYCLES - 1) ? WIDTH_W'(FRAME_CYCLES - 1) : f[WIDTH_W-1:0];
    endfunction

    function automatic logic [POS_W-1:0] slew_to(input logic [POS_W-1:0] a, input logic [POS_W-1:0] t);
        logic [POS_W-1:0] d;
        d = t > a ? t - a : a - t;
        if (SLEW_STEP != 0 && 32'(d) > SLEW_STEP) d = POS_W'(SLEW_STEP);
        return t > a ? a + d : a - d;
    endfunction

    assign last     = cnt == WIDTH_W'(FRAME_CYCLES - 1);
    assign boundary = enable && last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            pulse       <= '0;
            frame_start <= 1'b0;
            wr_err      <= 1'b0;
        end else begin
            cnt         <= enable && !last ? cnt + 1'b1 : '0;
            pulse       <= enable ? hit : '0;
            frame_start <= enable && cnt == '0;
            wr_err      <= wr_en && 32'(wr_ch) >= NUM_CH;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [POS_W-1:0] target, active;
        logic [WIDTH_W-1:0] width;
        assign hit[i] = cnt < width;
        // boundary reads the pre-write target; a same-edge write lands one frame later
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                target <= POS_W'(RESET_POS);
                active <= POS_W'(RESET_POS);
                width  <= calc_w(POS_W'(RESET_POS));
            end else begin
                if (wr_en && wr_ch == CH_W'(i)) target <= wr_pos;
                if (boundary) begin
                    active <= slew_to(active, target);
                    width  <= calc_w(slew_to(active, target));
                end
            end
        end
    end
endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb_servo_pwm_multi: scoreboard bench measuring per-frame pulse widths on an unlimited and a slew-limited instance.
module tb_servo_pwm_multi;
    logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1;
    logic wr_en = 1'b0, wr_en_s = 1'b0;
    logic [1:0] wr_ch = '0, wr_ch_s = '0;
    logic [3:0] wr_pos = '0, wr_pos_s = '0;
    logic wr_err, wr_err_s, frame_start, frame_start_s;
    logic [2:0] pulse, pulse_s;
    int n_chk = 0, n_err = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    servo_pwm_multi #(.NUM_CH(3), .POS_W(4), .FRAME_CYCLES(100), .MIN_CYCLES(10), .STEP_CYCLES(2),
                      .SLEW_STEP(0), .RESET_POS(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_ch(wr_ch), .wr_pos(wr_pos),
        .wr_err(wr_err), .frame_start(frame_start), .pulse(pulse));

    servo_pwm_multi #(.NUM_CH(3), .POS_W(4), .FRAME_CYCLES(100), .MIN_CYCLES(10), .STEP_CYCLES(2),
                      .SLEW_STEP(2), .RESET_POS(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en_s), .wr_ch(wr_ch_s), .wr_pos(wr_pos_s),
        .wr_err(wr_err_s), .frame_start(frame_start_s), .pulse(pulse_s));

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // counter value at the negedge k cycles after frame_start is k+1; a write driven at k lands on counter==k+1
    task automatic frame(input int e0, input int e1, input int e2, input int s0, input int s1, input int s2,
                         input int wr_at, input bit sel, input int ch, input int pos);
        int h[6] = '{default: 0};
        int fs = 0;
        int t = 0;
        exp_q.push_back(e0); exp_q.push_back(e1); exp_q.push_back(e2);
        exp_q.push_back(s0); exp_q.push_back(s1); exp_q.push_back(s2);
        while (!frame_start && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t == 300) check("frame_start timeout", 0, 1);
        for (int k = 0; k < 100; k++) begin
            for (int c = 0; c < 3; c++) begin
                h[c]     += int'(pulse[c]);
                h[c + 3] += int'(pulse_s[c]);
            end
            fs += int'(frame_start);
            if (k == wr_at + 1) check("wr_err pulse", int'(wr_err), int'(ch >= 3 && !sel));
            if (k == wr_at + 2) check("wr_err clear", int'(wr_err), 0);
            if (k == wr_at && sel) begin
                wr_en_s = 1'b1; wr_ch_s = 2'(ch); wr_pos_s = 4'(pos);
            end else if (k == wr_at) begin
                wr_en = 1'b1; wr_ch = 2'(ch); wr_pos = 4'(pos);
            end else begin
                wr_en = 1'b0; wr_en_s = 1'b0;
            end
            @(negedge clk);
        end
        check("frame_start count", fs, 1);
        for (int c = 0; c < 6; c++) check($sformatf("width %s ch%0d", c < 3 ? "dut" : "slew", c % 3), h[c], exp_q.pop_front());
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        check("reset pulse", int'(pulse), 0);
        check("reset pulse_s", int'(pulse_s), 0);
        check("reset frame_start", int'(frame_start), 0);
        check("reset wr_err", int'(wr_err), 0);
        check("reset wr_err_s", int'(wr_err_s), 0);
        rst_n = 1'b1;
        frame(26, 26, 26, 26, 26, 26, -1, 1'b0, 0, 0);
        frame(26, 26, 26, 26, 26, 26, 50, 1'b0, 1, 15);
        frame(26, 40, 26, 26, 26, 26, 98, 1'b0, 2, 3);
        frame(26, 40, 26, 26, 26, 26, -1, 1'b0, 0, 0);
        frame(26, 40, 16, 26, 26, 26, -1, 1'b0, 0, 0);
        frame(26, 40, 16, 26, 26, 26, 30, 1'b0, 3, 1);
        frame(26, 40, 16, 26, 26, 26, -1, 1'b0, 0, 0);
        frame(26, 40, 16, 26, 26, 26, 50, 1'b1, 0, 15);
        frame(26, 40, 16, 30, 26, 26, -1, 1'b0, 0, 0);
        frame(26, 40, 16, 34, 26, 26, -1, 1'b0, 0, 0);
        frame(26, 40, 16, 38, 26, 26, -1, 1'b0, 0, 0);
        frame(26, 40, 16, 40, 26, 26, -1, 1'b0, 0, 0);
        frame(26, 40, 16, 40, 26, 26, -1, 1'b0, 0, 0);
        t = 0;
        while (!frame_start && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t == 300) check("frame_start timeout", 0, 1);
        repeat (4) @(negedge clk);
        check("pre-drop pulse", int'(pulse), 7);
        enable = 1'b0;
        @(negedge clk);
        check("drop pulse", int'(pulse), 0);
        check("drop pulse_s", int'(pulse_s), 0);
        check("drop frame_start", int'(frame_start), 0);
        repeat (20) @(negedge clk);
        check("idle pulse", int'(pulse), 0);
        enable = 1'b1;
        @(negedge clk);
        check("reenable frame_start", int'(frame_start), 1);
        check("reenable pulse", int'(pulse), 7);
        frame(26, 40, 16, 40, 26, 26, -1, 1'b0, 0, 0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async reset pulse", int'(pulse), 0);
        check("async reset pulse_s", int'(pulse_s), 0);
        @(negedge clk);
        check("in-reset frame_start", int'(frame_start), 0);
        check("in-reset wr_err", int'(wr_err), 0);
        rst_n = 1'b1;
        frame(26, 26, 26, 26, 26, 26, -1, 1'b0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/servo_pwm_multi.md
Name: servo_pwm_multi

Overview:
Multi-channel servo PWM generator for the 50 MHz fabric, driving NUM_CH servos from one shared frame counter. It replaces single-channel, edge-triggered position loading with a clocked write port. New positions apply glitch-free only at frame boundaries, with optional per-frame slew limiting. It sits between the control logic (position commands) and the servo output pins.

Parameters:
NUM_CH, 4, number of servo channels (1..16)
POS_W, 8, position command width
FRAME_CYCLES, 1000000, frame period in clk cycles (20 ms @ 50 MHz)
MIN_CYCLES, 31000, pulse width for position 0
STEP_CYCLES, 392, added pulse cycles per position LSB
SLEW_STEP, 0, max position change per frame per channel; 0 = no limit (jump to target)
RESET_POS, 128, reset value of target and active positions

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run frames; low = outputs idle, counter held at 0
wr_en  in  1  position write strobe, single cycle, no backpressure
wr_ch  in  CH_W  channel index; CH_W = max(1, clog2(NUM_CH))
wr_pos  in  POS_W  target position
wr_err  out  1  one-cycle pulse: write with wr_ch >= NUM_CH was dropped
frame_start  out  1  one-cycle pulse when the counter is 0 while enabled
pulse  out  NUM_CH  servo PWM outputs, registered

Behaviour:
- Reset (rst_n low, asynchronous): counter=0, all targets and actives = RESET_POS, pulse=0, frame_start=0, wr_err=0. Release is synchronous to the next clk edge.
- Counter: with enable=1, counts 0..FRAME_CYCLES-1 and wraps to 0. With enable=0, counter is forced to 0 on each edge.
- frame_start: registered. High for exactly one cycle, the cycle after counter==0 with enable=1, i.e. aligned with the first high cycle of pulse.
- Writes:
  - wr_en=1 and wr_ch<NUM_CH: target[wr_ch] <= wr_pos on that edge. Accepted regardless of enable.
  - wr_en=1 and wr_ch>=NUM_CH: nothing updated; wr_err=1 for the next cycle.
  - Back-to-back writes are allowed. The last write to a channel before a boundary wins.
- Boundary update: only on the edge where enable=1 and counter==FRAME_CYCLES-1. For every channel:
  - SLEW_STEP=0: active <= target.
  - Otherwise: active moves toward target by min(SLEW_STEP, |target-active|); no overshoot.
  - A write on the boundary edge updates target only. The boundary uses the pre-write target, and the new value applies one frame later.
- Width: W_i = MIN_CYCLES + active_i*STEP_CYCLES.
  - Computed at full width, no truncation; WIDTH_W = clog2(FRAME_CYCLES)+1.
  - Saturated to FRAME_CYCLES-1, so duty is never 100%.
  - Held in a per-channel register, updated on the boundary edge from the new active value.
- Pulse: pulse_i(t+1) = enable(t) && (counter(t) < W_i).
  - Exactly W_i cycles high per frame, starting one cycle after counter==0.
  - Width is constant within a frame; no runt or split pulses.
- enable falls mid-frame: pulse and frame_start are 0 from the next edge; counter returns to 0. actives are held (no boundary update); targets still take writes.
- enable rises: the first frame starts with counter=0 using the held actives. Pending targets apply at the end of that frame.
- Reset mid-frame: outputs drop immediately (asynchronous); the frame restarts from 0 after release if enable=1.

Test Plan:
Sim params for all scenarios: FRAME_CYCLES=100, MIN_CYCLES=10, STEP_CYCLES=2, NUM_CH=3, POS_W=4, RESET_POS=8, SLEW_STEP=0.
1. Reset release, enable=1, no writes -> every channel pulse high 26 cycles per 100-cycle frame; frame_start period 100, rising with pulse.
2. Write ch1=15 mid-frame -> current frame still 26 cycles; next frame ch1 = 40 cycles; ch0 and ch2 stay 26.
3. Write ch2=3 on the counter==99 edge -> following frame ch2 = 26; the frame after = 16.
4. SLEW_STEP=2, write ch0=15 from 8 -> ch0 widths over successive frames 30, 34, 38, 40, 40.
5. Write wr_ch=3 -> wr_err high one cycle; no pulse width changes.
6. Drop enable at counter=5, then rst_n pulse mid-frame -> pulse=0 next edge (enable drop) or immediately (reset); re-enable -> first pulse starts one cycle after counter=0, full width.
